conv_enc_frame: RTL and testbench
=================================

Name: conv_enc_frame

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder (generators 7/5 octal, 4-state trellis).
- Sits ahead of the QAM mapper on the transmit side.
- Encodes a serial bit stream in fixed frames of FRAME_LEN bits and forces the trellis state to 0 at every frame start, so the 31-step Viterbi decoder on the receive side can start each frame from state 0.
- Optionally appends zero tail bits and emits a frame-start strobe for downstream alignment.

Parameters:
- FRAME_LEN, 31: encoded bit positions per frame, including tail positions.
- TAIL_BITS, 0: number of final frame positions forced to input 0. Range 0..FRAME_LEN-1.
- CNT_W, 5: width of the frame counter. Must satisfy 2^CNT_W >= FRAME_LEN.

Ports:
- clk, input, 1: system clock; all logic is rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- trigger_encode, input, 1: level enable. High = encoder running; low = abort or idle.
- data_in, input, 1: information bit.
- data_valid, input, 1: data_in is valid this cycle.
- data_ready, output, 1: encoder accepts data_in this cycle.
- conv_out, output, 2: coded pair to the QAM mapper. [1] = u^s[0], [0] = u^s[1]^s[0].
- conv_valid, output, 1: conv_out holds a new pair.
- frame_start, output, 1: one-cycle pulse, coincident with the first conv_valid of each frame.
- frame_count, output, CNT_W: position of the pair currently on conv_out (0..FRAME_LEN-1).

Behaviour:
- Trellis state s[1:0] = {u(t-1), u(t-2)}. Next state = {u, s[1]}.
- Coded outputs per (state, u), listed as {conv_out[1], conv_out[0]}:
  - u=0: s=00 -> 00, 01 -> 11, 10 -> 01, 11 -> 10.
  - u=1: s=00 -> 11, 01 -> 00, 10 -> 10, 11 -> 01.
- Reset (asynchronous, active-high):
  - fsm = IDLE, s = 0, internal position counter = 0.
  - conv_out = 0, conv_valid = 0, frame_start = 0, frame_count = 0, data_ready = 0.
- FSM states: IDLE, DATA, TAIL.
  - IDLE: data_ready = 0. trigger_encode = 1 -> DATA with position 0 and s = 0.
  - DATA: data_ready = trigger_encode. A step occurs on data_valid & data_ready.
  - TAIL: data_ready = 0. One step per cycle with u = 0; data_valid is ignored.
- Step (u, s, pos), with latency 1:
  - Next edge registers conv_out = f(s, u), conv_valid = 1, frame_count = pos, frame_start = (pos == 0).
  - s <= {u, s[1]}.
- No step in a cycle -> next edge registers conv_valid = 0 and frame_start = 0. conv_out and frame_count hold.
- Position sequencing:
  - Position increments per step.
  - After the step at pos = FRAME_LEN-TAIL_BITS-1, go to TAIL if TAIL_BITS > 0.
  - After the step at pos = FRAME_LEN-1: position wraps to 0, s forced to 0 (not {u, s[1]}), and fsm returns to DATA.
  - Frames are back-to-back with no gap cycle required.
- TAIL_BITS = 0: TAIL is never entered.
- Stall in DATA (data_valid = 0): state, position and s hold.
- trigger_encode falls in DATA or TAIL:
  - Abort the frame: go to IDLE, s = 0, position = 0. No step occurs that cycle.
  - The partial frame is discarded downstream by the missing frame_start.
- trigger_encode rising again starts a fresh frame at position 0.
- trigger_encode low in IDLE: remain idle, conv_valid = 0.
- Reset asserted mid-frame: immediate return to reset values. No pair in flight is emitted.
- Only one step per cycle is possible; no backpressure from the mapper (it accepts every conv_valid).

Test Plan:
- After reset, check conv_out = 00, conv_valid = 0, data_ready = 0. Raise trigger_encode and feed 1,0,1,1 back-to-back -> conv_out 11,01,00,10 on consecutive cycles, frame_start high only with 11, frame_count 0,1,2,3.
- Feed 31 consecutive zeros -> 31 pairs of 00. frame_start pulses at counts 0 and again at 31 (next frame). frame_count wraps 30 -> 0.
- Wrap state reset: bits 29 and 30 of the frame = 1,1 (state 11), first bit of next frame = 0 -> conv_out 00, not 10.
- Stall: data_valid low for 5 cycles between bits 1 and 2 of 1,0,1,1 -> conv_valid low for 5 cycles, and the pair sequence is still 11,01,00,10.
- TAIL_BITS = 2: data_ready drops after position 28. Positions 29 and 30 emit pairs with u = 0 and no input is consumed. data_ready returns at the next frame.
- Drop trigger_encode at position 10 -> conv_valid = 0 and data_ready = 0 the next cycle. Re-raise -> frame_start at position 0 with s = 0 (input 1 yields 11).

Source files
------------

// File: rtl/conv_enc_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_enc_frame                                                           |
// | Framed rate-1/2 K=3 (7/5) convolutional encoder with per-frame trellis   |
// | termination, optional zero tail and frame-start strobe.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv_enc_frame #(
    parameter int FRAME_LEN = 31,
    parameter int TAIL_BITS = 0,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger_encode,
    input  logic             data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic [1:0]       conv_out,
    output logic             conv_valid,
    output logic             frame_start,
    output logic [CNT_W-1:0] frame_count
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_DATA = 2'd1;
    localparam logic [1:0] c_S_TAIL = 2'd2;

    localparam logic [CNT_W-1:0] c_POS_LAST      = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_POS_DATA_LAST = CNT_W'(FRAME_LEN - TAIL_BITS - 1);
    localparam logic [CNT_W-1:0] c_POS_ONE       = CNT_W'(1);
    localparam bit               c_HAS_TAIL      = (TAIL_BITS > 0);

    logic [1:0]       r_state;
    logic [1:0]       r_s;
    logic [CNT_W-1:0] r_pos;
    logic [1:0]       r_conv_out;
    logic             r_conv_valid;
    logic             r_frame_start;
    logic [CNT_W-1:0] r_frame_count;

    logic [1:0]       w_state_nxt;
    logic [1:0]       w_s_nxt;
    logic [CNT_W-1:0] w_pos_nxt;
    logic             w_step;
    logic             w_u;
    logic             w_ready;
    logic [1:0]       w_pair;

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_pos_nxt   = r_pos;
        w_step      = 1'b0;
        w_u         = 1'b0;
        w_ready     = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                if (trigger_encode) begin
                    w_state_nxt = c_S_DATA;
                    w_s_nxt     = 2'b00;
                    w_pos_nxt   = '0;
                end
            end
            c_S_DATA: begin
                w_ready = trigger_encode;
                w_u     = data_in;
                w_step  = trigger_encode & data_valid;
            end
            c_S_TAIL: begin
                w_step = trigger_encode;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase

        w_pair = {w_u ^ r_s[0], w_u ^ r_s[1] ^ r_s[0]};

        // Dropping the trigger abandons the frame; no step is taken that cycle.
        if (r_state != c_S_IDLE && !trigger_encode) begin
            w_state_nxt = c_S_IDLE;
            w_s_nxt     = 2'b00;
            w_pos_nxt   = '0;
        end else if (w_step) begin
            if (r_pos == c_POS_LAST) begin
                // Frame boundary: the next frame starts from trellis state 0.
                w_state_nxt = c_S_DATA;
                w_s_nxt     = 2'b00;
                w_pos_nxt   = '0;
            end else begin
                w_s_nxt   = {w_u, r_s[1]};
                w_pos_nxt = r_pos + c_POS_ONE;
                if (c_HAS_TAIL && r_pos == c_POS_DATA_LAST) begin
                    w_state_nxt = c_S_TAIL;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_S_IDLE;
            r_s           <= 2'b00;
            r_pos         <= '0;
            r_conv_out    <= 2'b00;
            r_conv_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_s           <= w_s_nxt;
            r_pos         <= w_pos_nxt;
            r_conv_valid  <= w_step;
            r_frame_start <= w_step && (r_pos == '0);
            if (w_step) begin
                r_conv_out    <= w_pair;
                r_frame_count <= r_pos;
            end
        end
    end

    assign data_ready  = w_ready;
    assign conv_out    = r_conv_out;
    assign conv_valid  = r_conv_valid;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_conv_enc_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_enc_frame                                                        |
// | Checks conv_enc_frame (no tail and 2-bit tail) against a bit-history     |
// | reference model.                                                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_conv_enc_frame;

    localparam int c_FRAME_LEN = 31;
    localparam int c_CNT_W     = 5;

    logic clk;
    logic reset;
    logic trigger_encode;
    logic data_in;
    logic data_valid;

    logic [1:0]                 w_rdy;
    logic [1:0][1:0]            w_cout;
    logic [1:0]                 w_cval;
    logic [1:0]                 w_fs;
    logic [1:0][c_CNT_W-1:0]    w_cnt;

    conv_enc_frame #(.FRAME_LEN(c_FRAME_LEN), .TAIL_BITS(0), .CNT_W(c_CNT_W)) u_dut_notail (
        .clk(clk), .reset(reset), .trigger_encode(trigger_encode),
        .data_in(data_in), .data_valid(data_valid), .data_ready(w_rdy[0]),
        .conv_out(w_cout[0]), .conv_valid(w_cval[0]), .frame_start(w_fs[0]),
        .frame_count(w_cnt[0])
    );

    conv_enc_frame #(.FRAME_LEN(c_FRAME_LEN), .TAIL_BITS(2), .CNT_W(c_CNT_W)) u_dut_tail2 (
        .clk(clk), .reset(reset), .trigger_encode(trigger_encode),
        .data_in(data_in), .data_valid(data_valid), .data_ready(w_rdy[1]),
        .conv_out(w_cout[1]), .conv_valid(w_cval[1]), .frame_start(w_fs[1]),
        .frame_count(w_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: frame position plus the last two information bits.
    int tail_len [2] = '{0, 2};
    bit m_run    [2];
    int m_pos    [2];
    bit m_u1     [2];
    bit m_u2     [2];
    bit [1:0] e_out [2];
    int e_cnt    [2];
    bit e_val    [2];
    bit e_fs     [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 1'b0; m_pos[i] = 0; m_u1[i] = 1'b0; m_u2[i] = 1'b0;
            e_out[i] = 2'b00; e_cnt[i] = 0; e_val[i] = 1'b0; e_fs[i] = 1'b0;
        end
    endtask

    task automatic chk_outputs(input int i);
        string sfx;
        sfx = (i == 0) ? "_t0" : "_t2";
        chk({"conv_valid", sfx},  32'(w_cval[i]), 32'(e_val[i]));
        chk({"frame_start", sfx}, 32'(w_fs[i]),   32'(e_fs[i]));
        chk({"conv_out", sfx},    32'(w_cout[i]), 32'(e_out[i]));
        chk({"frame_count", sfx}, 32'(w_cnt[i]),  32'(e_cnt[i]));
    endtask

    // One clock: drive inputs at the falling edge, check ready, then outputs after the rising edge.
    task automatic cycle(input bit trig, input bit dv, input bit din);
        bit tail, step, u;
        bit stp [2];
        bit uu  [2];
        @(negedge clk);
        trigger_encode = trig; data_valid = dv; data_in = din;
        #1;
        for (int i = 0; i < 2; i++) begin
            tail   = m_run[i] && (m_pos[i] >= c_FRAME_LEN - tail_len[i]);
            step   = m_run[i] && trig && (tail || dv);
            u      = tail ? 1'b0 : din;
            stp[i] = step; uu[i] = u;
            chk((i == 0) ? "data_ready_t0" : "data_ready_t2", 32'(w_rdy[i]),
                32'(m_run[i] && trig && !tail));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            e_val[i] = stp[i];
            e_fs[i]  = stp[i] && (m_pos[i] == 0);
            if (stp[i]) begin
                e_out[i] = {uu[i] ^ m_u2[i], uu[i] ^ m_u1[i] ^ m_u2[i]};
                e_cnt[i] = m_pos[i];
                m_u2[i]  = m_u1[i];
                m_u1[i]  = uu[i];
                m_pos[i] = m_pos[i] + 1;
                if (m_pos[i] == c_FRAME_LEN) begin
                    m_pos[i] = 0; m_u1[i] = 1'b0; m_u2[i] = 1'b0;
                end
            end else if (m_run[i] != trig) begin
                m_run[i] = trig; m_pos[i] = 0; m_u1[i] = 1'b0; m_u2[i] = 1'b0;
            end
            chk_outputs(i);
        end
    endtask

    task automatic restart();
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bit [3:0] pat;
        bit [1:0] exp4 [4];
        trigger_encode = 1'b0; data_valid = 1'b0; data_in = 1'b0;
        reset = 1'b1;
        model_reset();
        #12;
        for (int i = 0; i < 2; i++) chk_outputs(i);
        chk("data_ready_reset", 32'(w_rdy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1,0,1,1 from a fresh frame
        exp4 = '{2'b11, 2'b01, 2'b00, 2'b10};
        pat  = 4'b1101;
        cycle(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, pat[k]);
            chk("seq1011_pair", 32'(w_cout[0]), 32'(exp4[k]));
            chk("seq1011_fs", 32'(w_fs[0]), 32'(k == 0));
        end

        // Same pattern with a 5-cycle stall after the second bit
        restart();
        for (int k = 0; k < 4; k++) begin
            if (k == 2) for (int j = 0; j < 5; j++) cycle(1'b1, 1'b0, 1'($urandom));
            cycle(1'b1, 1'b1, pat[k]);
            chk("stall_pair", 32'(w_cout[0]), 32'(exp4[k]));
        end

        // 31 zeros then the next frame's first pair
        restart();
        for (int k = 0; k < c_FRAME_LEN + 1; k++) cycle(1'b1, 1'b1, 1'b0);
        chk("zeros_wrap_fs", 32'(w_fs[0]), 32'd1);
        chk("zeros_wrap_cnt", 32'(w_cnt[0]), 32'd0);

        // Bits 29,30 = 1,1 then 0 at the next frame start must give 00
        restart();
        for (int k = 0; k < 29; k++) cycle(1'b1, 1'b1, 1'($urandom));
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("wrap_state_pair", 32'(w_cout[0]), 32'd0);
        chk("wrap_state_fs", 32'(w_fs[0]), 32'd1);

        // Abort at position 10, then restart from state 0
        restart();
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        chk("abort_valid", 32'(w_cval[0]), 32'd0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("abort_restart_pair", 32'(w_cout[0]), 32'd3);
        chk("abort_restart_fs", 32'(w_fs[0]), 32'd1);

        // Asynchronous reset in the middle of a frame
        for (int k = 0; k < 7; k++) cycle(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        trigger_encode = 1'b0;
        for (int i = 0; i < 2; i++) chk_outputs(i);
        @(negedge clk);
        reset = 1'b0;

        // Randomised traffic across both configurations
        for (int k = 0; k < 800; k++)
            cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
